// File: rtl/sbn_pkg.sv
// Shared constants and FSM state encoding for the SBN program loader.
package sbn_pkg;

    localparam int FWIDTH_DEF = 8;
    localparam int DWIDTH_DEF = 32;

    localparam logic [7:0] HDR_IMEM = 8'hA5;
    localparam logic [7:0] HDR_DMEM = 8'h5A;
    localparam logic [7:0] HDR_END  = 8'hFF;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CNT   = 3'd2,
        ST_BYTE  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/sbn_word_asm.sv
// Four-byte shift assembler: collects MSB-first bytes into a 32-bit word.
// word_o already includes byte_i, so it is the complete word in the cycle
// where done_o flags acceptance of the fourth byte.
module sbn_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [23:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;

    assign word_o = {word_q, byte_i};
    assign done_o = shift_i && (lane_q == 2'd3);

    // Shift in a byte and advance the lane on every accepted payload byte.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (shift_i) begin
            word_d = {word_q[15:0], byte_i};
            lane_d = lane_q + 2'd1;
        end
    end

    // Lane and partial word registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/sbn_loader.sv
// SBN program loader: parses a header/address/count/payload byte stream and
// writes assembled words into SBN instruction or data memory, then releases
// the machine with run. Handshake: a byte transfers on a clock edge where
// in_valid and in_ready are both high; in_ready depends only on state and rst.
module sbn_loader
    import sbn_pkg::*;
#(
    parameter int FWIDTH = FWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [FWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              run,
    output logic              err,
    output logic [2:0]        dbg_state
);

    state_t            state_q, state_d;
    logic [FWIDTH-1:0] addr_q, addr_d;
    logic [FWIDTH:0]   cnt_q, cnt_d;
    logic              imem_sel_q, imem_sel_d;
    logic [FWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic              ready_state;
    logic              xfer;
    logic              asm_shift;
    logic              asm_done;
    logic [31:0]       asm_word;

    assign ready_state = (state_q == ST_HDR) || (state_q == ST_ADDR) ||
                         (state_q == ST_CNT) || (state_q == ST_BYTE);
    assign in_ready    = ready_state && !rst;
    assign xfer        = in_valid && in_ready;
    assign asm_shift   = xfer && (state_q == ST_BYTE);

    assign imem_we   = (state_q == ST_WRITE) && imem_sel_q;
    assign dmem_we   = (state_q == ST_WRITE) && !imem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign run       = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign dbg_state = state_q;

    sbn_word_asm u_asm (
        .clk     (clk),
        .rst     (rst),
        .shift_i (asm_shift),
        .byte_i  (in_data),
        .word_o  (asm_word),
        .done_o  (asm_done)
    );

    // Next-state logic; DONE and ERR are terminal until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    if (in_data == HDR_IMEM || in_data == HDR_DMEM) state_d = ST_ADDR;
                    else if (in_data == HDR_END)                    state_d = ST_DONE;
                    else                                            state_d = ST_ERR;
                end
            end
            ST_ADDR:  if (xfer) state_d = ST_CNT;
            ST_CNT:   if (xfer) state_d = ST_BYTE;
            ST_BYTE:  if (asm_done) state_d = ST_WRITE;
            ST_WRITE: state_d = (cnt_q == {{FWIDTH{1'b0}}, 1'b1}) ? ST_HDR : ST_BYTE;
            ST_DONE:  state_d = ST_DONE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_ERR;
        endcase
    end

    // Datapath: latch header/address/count, capture the word for the write
    // cycle, then advance address and word count after each write.
    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        imem_sel_d  = imem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_HDR:  if (xfer) imem_sel_d = (in_data == HDR_IMEM);
            ST_ADDR: if (xfer) addr_d = in_data[FWIDTH-1:0];
            ST_CNT: begin
                // A count byte of zero encodes a full 256-word block.
                if (xfer) cnt_d = (in_data == 8'h00) ? {1'b1, {FWIDTH{1'b0}}}
                                                     : {1'b0, in_data[FWIDTH-1:0]};
            end
            ST_BYTE: begin
                if (asm_done) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = asm_word[DWIDTH-1:0];
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HDR;
            addr_q      <= '0;
            cnt_q       <= '0;
            imem_sel_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            imem_sel_q  <= imem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_sbn_loader.sv
// Directed bench for sbn_loader: stream scenarios with hand-computed writes.
module tb_sbn_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic        dmem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        run;
    logic        err;
    logic [2:0]  dbg_state;

    int  checks;
    int  errors;
    int  both_we;
    time last_xfer_t;

    typedef struct {
        logic        imem;
        logic [7:0]  addr;
        logic [31:0] data;
        time         t;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] exp_q[$];

    sbn_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .run       (run),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: log every strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we && dmem_we) both_we++;
        if (imem_we || dmem_we) begin
            wr_t w;
            w.imem = imem_we;
            w.addr = mem_addr;
            w.data = mem_wdata;
            w.t    = $time;
            wr_q.push_back(w);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        both_we = 0;
    endtask

    // Present one byte and hold it until it transfers; in_valid stays high.
    task automatic send_byte(input logic [7:0] b);
        bit r;
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (i > 0) @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) begin
                done = 1'b1;
                last_xfer_t = $time;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++; if ({imem_we, dmem_we} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b want 00", {imem_we, dmem_we}); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem: got %h/%h want 00/00000000", mem_addr, mem_wdata); end
        checks++; if ({run, err} !== 2'b00) begin errors++; $display("FAIL reset_run_err: got %b want 00", {run, err}); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
    endtask

    task automatic test_imem_single();
        time t4;
        do_reset();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        t4 = last_xfer_t;
        send_byte(8'hFF);
        idle(2);
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL imem_count: got %0d writes want 1", wr_q.size()); end
        if (wr_q.size() >= 1) begin
            checks++; if (wr_q[0].imem !== 1'b1) begin errors++; $display("FAIL imem_sel: got imem=%b want 1", wr_q[0].imem); end
            checks++; if (wr_q[0].addr !== 8'h10) begin errors++; $display("FAIL imem_addr: got %h want 10", wr_q[0].addr); end
            checks++; if (wr_q[0].data !== 32'h01020304) begin errors++; $display("FAIL imem_data: got %h want 01020304", wr_q[0].data); end
            checks++; if (wr_q[0].t != t4 + 5) begin errors++; $display("FAIL imem_latency: got t=%0t want %0t", wr_q[0].t, t4 + 5); end
        end
        checks++; if (run !== 1'b1 || in_ready !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL imem_done: got run=%b ready=%b err=%b want 1 0 0", run, in_ready, err); end
        checks++; if (mem_addr !== 8'h10 || mem_wdata !== 32'h01020304) begin errors++; $display("FAIL imem_hold: got %h/%h want 10/01020304", mem_addr, mem_wdata); end
    endtask

    task automatic test_dmem_wrap();
        logic [7:0]  exp_a [3];
        logic [31:0] exp_d [3];
        exp_a[0] = 8'hFE; exp_d[0] = 32'h00010203;
        exp_a[1] = 8'hFF; exp_d[1] = 32'h04050607;
        exp_a[2] = 8'h00; exp_d[2] = 32'h08090A0B;
        do_reset();
        send_byte(8'h5A); send_byte(8'hFE); send_byte(8'h03);
        for (int i = 0; i < 12; i++) send_byte(8'(i));
        idle(3);
        checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL wrap_count: got %0d writes want 3", wr_q.size()); end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].imem !== 1'b0 || wr_q[i].addr !== exp_a[i] || wr_q[i].data !== exp_d[i]) begin
                errors++;
                $display("FAIL wrap_write%0d: got imem=%b %h=%h want imem=0 %h=%h", i, wr_q[i].imem, wr_q[i].addr, wr_q[i].data, exp_a[i], exp_d[i]);
            end
        end
        checks++; if (dbg_state !== 3'd0 || in_ready !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL wrap_back_hdr: got state=%0d ready=%b run=%b want 0 1 0", dbg_state, in_ready, run); end
        checks++; if (both_we != 0) begin errors++; $display("FAIL wrap_both_we: got %0d want 0", both_we); end
    endtask

    task automatic test_bad_header();
        do_reset();
        send_byte(8'h33);
        @(negedge clk);
        checks++; if (err !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bad_hdr_err: got err=%b ready=%b want 1 0", err, in_ready); end
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (run !== 1'b0 || err !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bad_hdr_hold: got run=%b err=%b ready=%b want 0 1 0", run, err, in_ready); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        time p0;
        logic [7:0] pay [8];
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        pay[4] = 8'h55; pay[5] = 8'h66; pay[6] = 8'h77; pay[7] = 8'h88;
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(pay[0]);
        p0 = last_xfer_t;
        for (int i = 1; i < 8; i++) send_byte(pay[i]);
        checks++; if (last_xfer_t != p0 + 80) begin errors++; $display("FAIL b2b_rate: last byte at %0t want %0t", last_xfer_t, p0 + 80); end
        idle(3);
        checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d writes want 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0].addr !== 8'h00 || wr_q[0].data !== 32'h11223344 || wr_q[0].t != p0 + 35) begin errors++; $display("FAIL b2b_w0: got %h=%h t=%0t want 00=11223344 t=%0t", wr_q[0].addr, wr_q[0].data, wr_q[0].t, p0 + 35); end
            checks++; if (wr_q[1].addr !== 8'h01 || wr_q[1].data !== 32'h55667788 || wr_q[1].t != p0 + 85) begin errors++; $display("FAIL b2b_w1: got %h=%h t=%0t want 01=55667788 t=%0t", wr_q[1].addr, wr_q[1].data, wr_q[1].t, p0 + 85); end
        end
    endtask

    task automatic test_count_256();
        int bad;
        logic [31:0] w;
        do_reset();
        exp_q.delete();
        send_byte(8'h5A); send_byte(8'h40); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'hC3, 8'(i) ^ 8'h5A};
            exp_q.push_back(w);
            send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
        end
        idle(3);
        checks++; if (wr_q.size() != 256) begin errors++; $display("FAIL n256_count: got %0d writes want 256", wr_q.size()); end
        bad = 0;
        for (int i = 0; i < 256 && i < wr_q.size(); i++) begin
            if (wr_q[i].imem !== 1'b0 || wr_q[i].addr !== 8'(8'h40 + i) || wr_q[i].data !== exp_q[i]) begin
                if (bad == 0) $display("FAIL n256_write%0d: got imem=%b %h=%h want imem=0 %h=%h", i, wr_q[i].imem, wr_q[i].addr, wr_q[i].data, 8'(8'h40 + i), exp_q[i]);
                bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL n256_data: %0d bad writes want 0", bad); end
        checks++; if (dbg_state !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL n256_back_hdr: got state=%0d ready=%b want 0 1", dbg_state, in_ready); end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        send_byte(8'h12); send_byte(8'h34);
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL mid_pre_writes: got %0d want 1", wr_q.size()); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0 || in_ready !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL mid_reset_vals: got %h/%h ready=%b state=%0d want 00/00000000 0 0", mem_addr, mem_wdata, in_ready, dbg_state); end
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'hFF);
        idle(2);
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL mid_fresh_count: got %0d writes want 1", wr_q.size()); end
        if (wr_q.size() >= 1) begin
            checks++; if (wr_q[0].imem !== 1'b1 || wr_q[0].addr !== 8'h30 || wr_q[0].data !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_fresh_write: got imem=%b %h=%h want imem=1 30=deadbeef", wr_q[0].imem, wr_q[0].addr, wr_q[0].data); end
        end
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL mid_fresh_run: got %b want 1", run); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        both_we  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        last_xfer_t = 0;
        test_reset();
        test_imem_single();
        test_dmem_wrap();
        test_bad_header();
        test_back_to_back();
        test_count_256();
        test_reset_mid_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbn_loader.md
SBN_LOADER -- requirements
Module: sbn_loader

Interface
REQ-001 Parameter FWIDTH, default 8, SBN operand field width and memory address width; only 8 is supported.
REQ-002 Parameter DWIDTH, default 32, data word width; equals instruction width 4*FWIDTH.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  byte stream from host link.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts a byte; a byte transfers when in_valid and in_ready are both high at a clock edge.
REQ-008 imem_we  output  1  one-cycle write strobe to SBN instruction memory.
REQ-009 dmem_we  output  1  one-cycle write strobe to SBN data memory.
REQ-010 mem_addr  output  FWIDTH  write address for imem or dmem.
REQ-011 mem_wdata  output  DWIDTH  assembled write word; for imem, fields are A,B,C,D from MSB to LSB.
REQ-012 run  output  1  program loaded; SBN machine is released from hold.
REQ-013 err  output  1  sticky frame error.

Function
REQ-014 A stream is a sequence of blocks; each block starts with a header byte: 0xA5 = imem block, 0x5A = dmem block, 0xFF = end of load.
REQ-015 An imem or dmem block continues with a start-address byte, then a count byte (N words; 0 encodes 256), then N*4 payload bytes, most-significant byte first.
REQ-016 The FSM has these states: HDR, ADDR, CNT, BYTE, WRITE, DONE, ERR.
REQ-017 FSM transitions: HDR->ADDR on 0xA5/0x5A; HDR->DONE on 0xFF; HDR->ERR on any other byte; ADDR->CNT; CNT->BYTE.
REQ-018 The byte-lane counter counts 0..3; BYTE->WRITE when the 4th byte of a word is accepted.
REQ-019 WRITE lasts exactly one cycle: exactly one of imem_we or dmem_we is high (selected by the latched header), mem_addr = current address, and mem_wdata = the assembled word.
REQ-020 From WRITE the FSM goes to BYTE if words remain, otherwise to HDR.
REQ-021 Write latency: the strobe is high in the cycle immediately after the transfer of the 4th byte.
REQ-022 in_ready is high in HDR, ADDR, CNT and BYTE, and low in WRITE, DONE and ERR; this gives a sustained rate of 4 bytes per 5 cycles.
REQ-023 Bytes presented while in_ready is low are not consumed; in_data may change freely while in_valid is low.
REQ-024 The address increments by 1 after each WRITE and wraps 255->0 within a block with no error.
REQ-025 The word counter uses FWIDTH+1 bits so that N=256 is represented.
REQ-026 Outside WRITE, imem_we and dmem_we are 0; mem_addr and mem_wdata hold their last values.
REQ-027 In DONE, run=1 and the state holds until reset.
REQ-028 In ERR, err=1, run=0, in_ready=0, and the state holds until reset.
REQ-029 A block with N words overwrites earlier contents at the same addresses; the last write wins.

Reset
REQ-030 While rst is high, or asynchronously on its assertion: state=HDR, in_ready=0, imem_we=0, dmem_we=0, mem_addr=0, mem_wdata=0, run=0, err=0, and all counters=0.
REQ-031 in_ready becomes high in the first cycle after rst deasserts.
REQ-032 A reset asserted mid-block aborts the block; words already written are not rolled back, and any partial word is discarded.

Structure
REQ-033 A shared package sbn_pkg holds the header constants HDR_IMEM=0xA5, HDR_DMEM=0x5A and HDR_END=0xFF, the FSM state encoding, and the FWIDTH/DWIDTH defaults.
REQ-034 The block contains one sub-module, sbn_word_asm: a 4-byte shift assembler with lane counter and a word-complete flag.

Verification
REQ-035 Stream A5,10,01,01,02,03,04,FF -> one imem_we pulse with mem_addr=0x10 and mem_wdata=0x01020304, then run=1 and in_ready=0.
REQ-036 Stream 5A,FE,03 followed by 12 bytes 00..0B -> dmem writes at FE=0x00010203, FF=0x04050607, 00=0x08090A0B (wrap-around), then the FSM returns to HDR.
REQ-037 Header 0x33 -> err=1 and in_ready=0 in the next cycle; a further byte 0xFF leaves run at 0.
REQ-038 in_valid held high back-to-back -> in_ready low exactly one cycle per word, no byte lost or duplicated, and 2 words written in 10 cycles of payload.
REQ-039 Count byte 00 with 1024 payload bytes -> 256 dmem writes covering addresses start..start-1, then return to HDR.
REQ-040 rst pulsed after 2 payload bytes -> outputs take reset values immediately; a fresh A5 stream afterwards loads correctly with no stray write.
